hub_arbiter: RTL and testbench

HUB_ARBITER -- requirements
Module: hub_arbiter

---
 rtl/hub_arbiter.sv | 121 ++++++++++++
 tb/tb_hub_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/hub_arbiter.sv
// rtl/hub_arbiter.sv - two-requester round-robin arbiter for one shared slave port
// Ownership is held per burst, released on last or after MAX_BEATS transfers.
module hub_arbiter #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BEATS  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_valid,
  input  logic                  m0_last,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ready,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_valid,
  input  logic                  m1_last,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ready,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  s_valid,
  output logic                  s_last,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [DATA_WIDTH-1:0] s_wdata,
  input  logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  output logic                  owner,
  output logic                  busy
);

  localparam int CNT_W = $clog2(MAX_BEATS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_winner_q, last_winner_d;

  logic cur_valid, cur_last, oth_valid;

  assign cur_valid = (state_q == OWN1) ? m1_valid : m0_valid;
  assign cur_last  = (state_q == OWN1) ? m1_last  : m0_last;
  assign oth_valid = (state_q == OWN1) ? m0_valid : m1_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      last_winner_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_winner_q <= last_winner_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_winner_d = last_winner_q;
    case (state_q)
      IDLE: begin
        // On a tie the requester that did not win last time gets the slave.
        if (m0_valid && m1_valid) state_d = last_winner_q ? OWN0 : OWN1;
        else if (m0_valid)        state_d = OWN0;
        else if (m1_valid)        state_d = OWN1;
      end
      OWN0, OWN1: begin
        if (cur_valid && s_ready) begin
          if (cur_last || cnt_q == CNT_MAX) begin
            cnt_d         = '0;
            last_winner_d = (state_q == OWN1);
            if (oth_valid) state_d = (state_q == OWN1) ? OWN0 : OWN1;
            else           state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m0_ready = 1'b0;
    m0_rdata = '0;
    m1_ready = 1'b0;
    m1_rdata = '0;
    s_valid  = 1'b0;
    s_last   = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    owner    = 1'b0;
    busy     = 1'b0;
    case (state_q)
      OWN0: begin
        s_valid  = m0_valid;
        s_last   = m0_last;
        s_addr   = m0_addr;
        s_wdata  = m0_wdata;
        m0_ready = s_ready;
        m0_rdata = s_rdata;
        busy     = 1'b1;
      end
      OWN1: begin
        s_valid  = m1_valid;
        s_last   = m1_last;
        s_addr   = m1_addr;
        s_wdata  = m1_wdata;
        m1_ready = s_ready;
        m1_rdata = s_rdata;
        busy     = 1'b1;
        owner    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hub_arbiter.sv
// tb/tb_hub_arbiter.sv - bench for hub_arbiter
// Behavioural ownership model plus directed scenarios and randomized traffic.
module tb_hub_arbiter;

  localparam int DW = 4;
  localparam int AW = 32;
  localparam int MB = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_valid = 0, m0_last = 0, m1_valid = 0, m1_last = 0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic          m0_ready, m1_ready;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          s_valid, s_last;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic          s_ready = 0;
  logic [DW-1:0] s_rdata = '0;
  logic          owner, busy;

  int n_tests = 0;
  int n_fail  = 0;

  hub_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_valid(m0_valid), .m0_last(m0_last), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_last(m1_last), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_last(s_last), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: who owns the slave (-1 = nobody), beats moved in this tenure, last winner.
  int m_own = -1;
  int m_cnt = 0;
  int m_lw  = 1;

  always @(posedge clk or negedge rst_n) begin
    int nown, ncnt, nlw, x;
    bit vx, lx, vo;
    if (!rst_n) begin
      m_own <= -1;
      m_cnt <= 0;
      m_lw  <= 1;
    end else begin
      nown = m_own; ncnt = m_cnt; nlw = m_lw;
      if (m_own < 0) begin
        if (m0_valid && m1_valid) nown = 1 - m_lw;
        else if (m0_valid)        nown = 0;
        else if (m1_valid)        nown = 1;
      end else begin
        x  = m_own;
        vx = (x == 0) ? m0_valid : m1_valid;
        lx = (x == 0) ? m0_last  : m1_last;
        vo = (x == 0) ? m1_valid : m0_valid;
        if (vx && s_ready) begin
          ncnt = m_cnt + 1;
          if (lx || ncnt == MB) begin
            ncnt = 0;
            nlw  = x;
            nown = vo ? 1 - x : -1;
          end
        end
      end
      m_own <= nown;
      m_cnt <= ncnt;
      m_lw  <= nlw;
    end
  end

  task automatic chk_model();
    logic [49:0] exp_v, act_v;
    logic        e_r0, e_r1, e_sv, e_sl;
    logic [DW-1:0] e_d0, e_d1, e_sw;
    logic [AW-1:0] e_sa;
    e_r0 = 0; e_r1 = 0; e_d0 = '0; e_d1 = '0; e_sv = 0; e_sl = 0; e_sa = '0; e_sw = '0;
    if (m_own == 0) begin
      e_sv = m0_valid; e_sl = m0_last; e_sa = m0_addr; e_sw = m0_wdata;
      e_r0 = s_ready;  e_d0 = s_rdata;
    end else if (m_own == 1) begin
      e_sv = m1_valid; e_sl = m1_last; e_sa = m1_addr; e_sw = m1_wdata;
      e_r1 = s_ready;  e_d1 = s_rdata;
    end
    exp_v = {m_own >= 0, m_own == 1, e_r0, e_r1, e_d0, e_d1, e_sv, e_sl, e_sa, e_sw};
    act_v = {busy, owner, m0_ready, m1_ready, m0_rdata, m1_rdata, s_valid, s_last, s_addr, s_wdata};
    n_tests++;
    if (exp_v !== act_v) begin
      n_fail++;
      $display("FAIL outputs t=%0t got %h want %h", $time, act_v, exp_v);
    end
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got %h want %h", name, $time, act, exp);
    end
  endtask

  // One cycle: drive at the falling edge, check the settled outputs shortly after.
  task automatic cyc(input bit v0, input bit l0, input bit v1, input bit l1, input bit sr);
    @(negedge clk);
    m0_valid = v0; m0_last = l0; m1_valid = v1; m1_last = l1; s_ready = sr;
    m0_addr = $urandom; m1_addr = $urandom;
    m0_wdata = DW'($urandom); m1_wdata = DW'($urandom); s_rdata = DW'($urandom);
    #1;
    chk_model();
  endtask

  initial begin
    // Reset held with both requesters valid: everything quiet.
    cyc(1, 0, 1, 0, 1);
    lit("reset_busy", {31'd0, busy}, 0);
    cyc(1, 0, 1, 0, 1);
    lit("reset_outs", {28'd0, owner, m0_ready, m1_ready, s_valid}, 0);
    rst_n = 1'b1;
    #1;
    lit("cycle0_idle", {31'd0, busy}, 0);
    lit("cycle0_sv", {31'd0, s_valid}, 0);
    cyc(1, 0, 1, 0, 1);
    lit("c1_busy_owner", {30'd0, busy, owner}, 32'h2);
    lit("model_own_c1", m_own, 0);
    lit("c1_m0_ready", {31'd0, m0_ready}, 1);
    cyc(1, 0, 1, 0, 1);
    cyc(1, 1, 1, 0, 1);
    lit("c3_m0_ready", {31'd0, m0_ready}, 1);
    cyc(0, 0, 1, 1, 1);
    lit("c4_no_bubble", {30'd0, busy, owner}, 32'h3);
    lit("model_own_c4", m_own, 1);
    cyc(0, 0, 0, 0, 1);
    lit("c5_idle", {31'd0, busy}, 0);

    // m1 alone, one beat, slave stalls two cycles.
    cyc(0, 0, 1, 1, 1);
    lit("m1_arb_cycle", {31'd0, m1_ready}, 0);
    cyc(0, 0, 1, 1, 0);
    lit("m1_stall1", {29'd0, busy, owner, m1_ready}, 32'h6);
    cyc(0, 0, 1, 1, 0);
    lit("m1_stall2", {31'd0, m1_ready}, 0);
    cyc(0, 0, 1, 1, 1);
    lit("m1_xfer", {31'd0, m1_ready}, 1);
    cyc(0, 0, 0, 0, 1);
    lit("m1_done", {30'd0, busy, owner}, 0);

    // m0 streams without last; forced release after MB transfers.
    cyc(1, 0, 1, 0, 1);
    for (int i = 0; i < MB; i++) begin
      cyc(1, 0, 1, 0, 1);
      lit("max_hold", {30'd0, busy, owner}, 32'h2);
    end
    cyc(1, 0, 1, 1, 1);
    lit("max_handoff", {30'd0, busy, owner}, 32'h3);
    cyc(1, 0, 1, 0, 1);
    lit("m0_regain", {30'd0, busy, owner}, 32'h2);

    // Owner goes quiet mid-burst; the other requester must wait.
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 0, 1);
      lit("stall_hold", {29'd0, busy, owner, m1_ready}, 32'h4);
    end
    for (int i = 0; i < MB - 1; i++) begin
      cyc(1, 0, 1, 0, 1);
      lit("stall_count", {31'd0, owner}, 0);
    end
    cyc(1, 0, 1, 0, 1);
    lit("stall_release", {31'd0, owner}, 1);
    s_rdata = 4'hA;
    #1;
    lit("rdata_m1", {28'd0, m1_rdata}, 32'hA);
    lit("rdata_m0", {28'd0, m0_rdata}, 0);

    // Asynchronous reset mid-burst.
    cyc(1, 0, 1, 0, 1);
    rst_n = 1'b0;
    #1;
    chk_model();
    lit("async_rst", {27'd0, busy, owner, m0_ready, m1_ready, s_valid}, 0);
    cyc(1, 0, 1, 0, 1);
    rst_n = 1'b1;
    cyc(1, 0, 1, 0, 1);
    lit("post_rst_tie", {30'd0, busy, owner}, 32'h2);

    // Randomized traffic with occasional reset pulses.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 5) == 0,
          $urandom_range(0, 9) < 7, $urandom_range(0, 5) == 0,
          $urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        #1;
        chk_model();
        cyc(1, 0, 1, 0, 1);
        rst_n = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
